// File: rtl/byte_rx_serial_pkg.sv
// Shared constants for the serial byte receiver: comma symbol and FSM state encoding.
package byte_rx_serial_pkg;

    localparam logic [7:0] ComSymbol = 8'hBC;

    typedef enum logic [1:0] {
        StSearch = 2'd0,
        StSync   = 2'd1,
        StLocked = 2'd2
    } rx_state_e;

endpackage

// File: rtl/byte_rx_serial_com_detector.sv
// Combinational match of one byte against the comma symbol; shared with the TX side.
module byte_rx_serial_com_detector
    import byte_rx_serial_pkg::*;
#(
    parameter logic [7:0] COM = ComSymbol
) (
    input  logic [7:0] byte_val,
    output logic       is_com
);

    assign is_com = (byte_val == COM);

endmodule

// File: rtl/byte_rx_serial.sv
// Serial-to-byte receiver: hunts for COM alignment, locks after LOCK_COUNT aligned COMs,
// then strobes out every non-COM byte.
module byte_rx_serial
    import byte_rx_serial_pkg::*;
#(
    parameter logic [7:0]  COM        = ComSymbol,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active,
    output logic       com_det
);

    localparam logic [3:0] LockCnt = 4'(LOCK_COUNT);

    rx_state_e  state;
    // Only the seven most recent bits are stored; data_in supplies the eighth.
    logic [6:0] sr;
    logic [2:0] bit_cnt;
    logic [3:0] com_cnt;
    logic [7:0] sr_next;
    logic       is_com;
    logic       boundary;

    assign sr_next  = {sr, data_in};
    assign boundary = (bit_cnt == 3'd7);

    byte_rx_serial_com_detector #(
        .COM (COM)
    ) u_com_detector (
        .byte_val (sr_next),
        .is_com   (is_com)
    );

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state     <= StSearch;
            sr        <= '0;
            bit_cnt   <= '0;
            com_cnt   <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            active    <= 1'b0;
            com_det   <= 1'b0;
        end else begin
            sr        <= sr_next[6:0];
            valid_out <= 1'b0;
            com_det   <= 1'b0;
            unique case (state)
                StSearch: begin
                    bit_cnt <= '0;
                    if (is_com) begin
                        com_det <= 1'b1;
                        com_cnt <= 4'd1;
                        if (LOCK_COUNT == 1) begin
                            state  <= StLocked;
                            active <= 1'b1;
                        end else begin
                            state <= StSync;
                        end
                    end
                end
                StSync: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (boundary) begin
                        if (is_com) begin
                            com_det <= 1'b1;
                            com_cnt <= com_cnt + 4'd1;
                            if (com_cnt + 4'd1 == LockCnt) begin
                                state  <= StLocked;
                                active <= 1'b1;
                            end
                        end else begin
                            state   <= StSearch;
                            com_cnt <= '0;
                            bit_cnt <= '0;
                        end
                    end
                end
                StLocked: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (boundary) begin
                        if (is_com) begin
                            com_det <= 1'b1;
                        end else begin
                            data_out  <= sr_next;
                            valid_out <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= StSearch;
                    bit_cnt <= '0;
                    com_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_rx_serial.sv
// Self-checking bench for byte_rx_serial against a bit-window reference model.
module tb_byte_rx_serial;

    localparam int LOCK = 4;
    localparam int COMV = 8'hBC;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    logic       com_det;

    int errors = 0;
    int checks = 0;

    // Reference model: last 8 bits as an integer, bits since alignment, mode 0/1/2.
    int         m_mode;
    int         m_win;
    int         m_phase;
    int         m_coms;
    logic [7:0] m_data;
    logic       m_valid, m_com, m_active;

    int         cyc;
    int         n_com, n_valid;
    logic [7:0] got_q[$];
    int         got_cyc[$];

    always #5 CLK = ~CLK;

    byte_rx_serial #(
        .LOCK_COUNT (LOCK)
    ) dut (
        .CLK       (CLK),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active),
        .com_det   (com_det)
    );

    function automatic void model_reset();
        m_mode = 0; m_win = 0; m_phase = 0; m_coms = 0;
        m_data = 8'h00; m_valid = 1'b0; m_com = 1'b0; m_active = 1'b0;
    endfunction

    function automatic void model_bit(input bit b);
        m_win   = ((m_win << 1) | int'(b)) & 255;
        m_valid = 1'b0;
        m_com   = 1'b0;
        if (m_mode == 0) begin
            if (m_win == COMV) begin
                m_com = 1'b1; m_coms = 1; m_phase = 0;
                if (LOCK == 1) begin m_mode = 2; m_active = 1'b1; end
                else m_mode = 1;
            end
        end else begin
            m_phase = (m_phase + 1) % 8;
            if (m_phase == 0) begin
                if (m_mode == 1) begin
                    if (m_win == COMV) begin
                        m_com = 1'b1; m_coms++;
                        if (m_coms == LOCK) begin m_mode = 2; m_active = 1'b1; end
                    end else begin
                        m_mode = 0; m_coms = 0;
                    end
                end else if (m_win == COMV) begin
                    m_com = 1'b1;
                end else begin
                    m_valid = 1'b1; m_data = 8'(m_win);
                end
            end
        end
    endfunction

    task automatic drive_bit(input bit b);
        data_in = b;
        model_bit(b);
        @(posedge CLK);
        #1;
        cyc++;
        if (com_det) n_com++;
        if (valid_out) begin
            n_valid++;
            got_q.push_back(data_out);
            got_cyc.push_back(cyc);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        data_in = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #3 reset = 1'b1;
        n_com = 0; n_valid = 0; got_q.delete(); got_cyc.delete();
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        if ({active, valid_out, com_det, data_out} !== 11'd0) begin
            errors++;
            $display("FAIL reset_state got a/v/c/d=%b/%b/%b/%h want 0/0/0/00",
                     active, valid_out, com_det, data_out);
        end
        checks++;
        apply_reset();
    endtask

    task automatic test_zeros();
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            drive_bit(1'b0);
            if ({active, valid_out, com_det, data_out} !== {m_active, m_valid, m_com, m_data}) begin
                errors++;
                $display("FAIL zeros_cycle got %b/%b/%b/%h want %b/%b/%b/%h", active, valid_out,
                         com_det, data_out, m_active, m_valid, m_com, m_data);
            end
            checks++;
        end
        if (n_com != 0 || n_valid != 0 || active !== 1'b0) begin
            errors++;
            $display("FAIL zeros_quiet got com=%0d valid=%0d active=%b want 0/0/0",
                     n_com, n_valid, active);
        end
        checks++;
    endtask

    task automatic test_lock();
        logic [7:0] q[$] = '{8'h25, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hF9, 8'h4F};
        apply_reset();
        repeat (3) drive_bit(1'($urandom_range(0, 1)));
        foreach (q[i]) for (int k = 7; k >= 0; k--) begin
            drive_bit(q[i][k]);
            if ({active, valid_out, com_det, data_out} !== {m_active, m_valid, m_com, m_data}) begin
                errors++;
                $display("FAIL lock_cycle got %b/%b/%b/%h want %b/%b/%b/%h", active, valid_out,
                         com_det, data_out, m_active, m_valid, m_com, m_data);
            end
            checks++;
        end
        if (n_com != 4 || got_q.size() != 2 || got_cyc.size() != 2) begin
            errors++;
            $display("FAIL lock_counts got com=%0d valid=%0d want com=4 valid=2",
                     n_com, got_q.size());
        end else if (got_q[0] !== 8'hF9 || got_q[1] !== 8'h4F || got_cyc[1] - got_cyc[0] != 8) begin
            errors++;
            $display("FAIL lock_bytes got %h,%h gap=%0d want f9,4f gap=8",
                     got_q[0], got_q[1], got_cyc[1] - got_cyc[0]);
        end
        checks++;
    endtask

    task automatic test_realign();
        logic [7:0] q[$] = '{8'hBC, 8'hBC, 8'hA6, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h39};
        apply_reset();
        foreach (q[i]) for (int k = 7; k >= 0; k--) begin
            drive_bit(q[i][k]);
            if ({active, valid_out, com_det, data_out} !== {m_active, m_valid, m_com, m_data}) begin
                errors++;
                $display("FAIL realign_cycle got %b/%b/%b/%h want %b/%b/%b/%h", active, valid_out,
                         com_det, data_out, m_active, m_valid, m_com, m_data);
            end
            checks++;
        end
        if (n_com != 6 || got_q.size() != 1 || active !== 1'b1) begin
            errors++;
            $display("FAIL realign_counts got com=%0d valid=%0d active=%b want 6/1/1",
                     n_com, got_q.size(), active);
        end else if (got_q[0] !== 8'h39) begin
            errors++;
            $display("FAIL realign_byte got %h want 39", got_q[0]);
        end
        checks++;
    endtask

    task automatic test_locked_com();
        logic [7:0] q[$] = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hF9, 8'hBC, 8'hA8};
        apply_reset();
        foreach (q[i]) for (int k = 7; k >= 0; k--) begin
            drive_bit(q[i][k]);
            if ({active, valid_out, com_det, data_out} !== {m_active, m_valid, m_com, m_data}) begin
                errors++;
                $display("FAIL locked_com_cycle got %b/%b/%b/%h want %b/%b/%b/%h", active,
                         valid_out, com_det, data_out, m_active, m_valid, m_com, m_data);
            end
            checks++;
            if (com_det && n_com == 5) begin
                if (data_out !== 8'hF9 || valid_out !== 1'b0) begin
                    errors++;
                    $display("FAIL locked_com_hold got d=%h v=%b want f9/0", data_out, valid_out);
                end
                checks++;
            end
        end
        if (n_com != 5 || got_q.size() != 2) begin
            errors++;
            $display("FAIL locked_com_counts got com=%0d valid=%0d want 5/2", n_com, got_q.size());
        end else if (got_q[0] !== 8'hF9 || got_q[1] !== 8'hA8) begin
            errors++;
            $display("FAIL locked_com_bytes got %h,%h want f9,a8", got_q[0], got_q[1]);
        end
        checks++;
    endtask

    task automatic test_misaligned();
        logic [7:0] q[$] = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h0B, 8'hC0};
        apply_reset();
        foreach (q[i]) for (int k = 7; k >= 0; k--) begin
            drive_bit(q[i][k]);
            if ({active, valid_out, com_det, data_out} !== {m_active, m_valid, m_com, m_data}) begin
                errors++;
                $display("FAIL misaligned_cycle got %b/%b/%b/%h want %b/%b/%b/%h", active,
                         valid_out, com_det, data_out, m_active, m_valid, m_com, m_data);
            end
            checks++;
        end
        if (n_com != 4 || got_q.size() != 2) begin
            errors++;
            $display("FAIL misaligned_counts got com=%0d valid=%0d want 4/2", n_com, got_q.size());
        end else if (got_q[0] !== 8'h0B || got_q[1] !== 8'hC0) begin
            errors++;
            $display("FAIL misaligned_bytes got %h,%h want 0b,c0", got_q[0], got_q[1]);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] q[$] = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hF9, 8'h4F};
        apply_reset();
        foreach (q[i]) for (int k = 7; k >= 0; k--) begin
            if (i == 5 && k == 3) break;
            drive_bit(q[i][k]);
            if ({active, valid_out, com_det, data_out} !== {m_active, m_valid, m_com, m_data}) begin
                errors++;
                $display("FAIL reset_mid_cycle got %b/%b/%b/%h want %b/%b/%b/%h", active,
                         valid_out, com_det, data_out, m_active, m_valid, m_com, m_data);
            end
            checks++;
        end
        #2 reset = 1'b0;
        #1;
        if ({active, valid_out, com_det, data_out} !== 11'd0) begin
            errors++;
            $display("FAIL reset_mid_async got a/v/c/d=%b/%b/%b/%h want 0/0/0/00",
                     active, valid_out, com_det, data_out);
        end
        checks++;
        @(posedge CLK);
        #3 reset = 1'b1;
        model_reset();
        for (int j = 0; j < 4; j++) begin
            for (int k = 7; k >= 0; k--) begin
                drive_bit(1'((COMV >> k) & 1));
                if ({active, valid_out, com_det, data_out} !== {m_active, m_valid, m_com, m_data}) begin
                    errors++;
                    $display("FAIL relock_cycle got %b/%b/%b/%h want %b/%b/%b/%h", active,
                             valid_out, com_det, data_out, m_active, m_valid, m_com, m_data);
                end
                checks++;
            end
            if (active !== (j == 3)) begin
                errors++;
                $display("FAIL relock_active after %0d COMs got %b want %b", j + 1, active, j == 3);
            end
            checks++;
        end
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        int         exp_valid = 0;
        apply_reset();
        repeat (4) q.push_back(8'hBC);
        for (int i = 0; i < 30; i++) begin
            q.push_back(($urandom_range(0, 4) == 0) ? 8'hBC : 8'($urandom));
            if (q[q.size() - 1] != 8'hBC) exp_valid++;
        end
        repeat (1 + $urandom_range(0, 6)) drive_bit(1'b0);
        foreach (q[i]) for (int k = 7; k >= 0; k--) begin
            drive_bit(q[i][k]);
            if ({active, valid_out, com_det, data_out} !== {m_active, m_valid, m_com, m_data}) begin
                errors++;
                $display("FAIL random_cycle got %b/%b/%b/%h want %b/%b/%b/%h", active, valid_out,
                         com_det, data_out, m_active, m_valid, m_com, m_data);
            end
            checks++;
        end
        if (n_valid != exp_valid) begin
            errors++;
            $display("FAIL random_count got valid=%0d want %0d", n_valid, exp_valid);
        end
        checks++;
    endtask

    initial begin
        cyc = 0;
        model_reset();
        test_reset();
        test_zeros();
        test_lock();
        test_realign();
        test_locked_com();
        test_misaligned();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
